// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared opcode, funct and ALU operation encodings plus widths,
// the same values the combinational ALU decodes.
package alu_issue_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int OPRN_W = 6;
    localparam int REG_W  = 5;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_MULI  = 6'h1D;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h2C;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [OPRN_W-1:0] OPRN_NOP = 6'h00;
    localparam logic [OPRN_W-1:0] OPRN_ADD = 6'h01;
    localparam logic [OPRN_W-1:0] OPRN_SUB = 6'h02;
    localparam logic [OPRN_W-1:0] OPRN_MUL = 6'h03;
    localparam logic [OPRN_W-1:0] OPRN_SRL = 6'h04;
    localparam logic [OPRN_W-1:0] OPRN_SLL = 6'h05;
    localparam logic [OPRN_W-1:0] OPRN_AND = 6'h06;
    localparam logic [OPRN_W-1:0] OPRN_OR  = 6'h07;
    localparam logic [OPRN_W-1:0] OPRN_NOR = 6'h08;
    localparam logic [OPRN_W-1:0] OPRN_SLT = 6'h09;

    typedef enum logic [1:0] {OP2_RT, OP2_SHAMT, OP2_SEXT, OP2_ZEXT} op2_sel_t;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/alu_instr_decode.sv
// alu_instr_decode: combinational MIPS decode into ALU operation, operand-2 source,
// destination register and illegal flag.
module alu_instr_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [OPRN_W-1:0] oprn,
    output op2_sel_t          op2_sel,
    output logic [REG_W-1:0]  dest,
    output logic              illegal
);
    always_comb begin
        oprn    = OPRN_NOP;
        op2_sel = OP2_RT;
        dest    = instr[20:16];
        illegal = 1'b0;
        if (instr[31:26] == OPC_RTYPE) begin
            dest = instr[15:11];
            case (instr[5:0])
                FN_ADD:  oprn = OPRN_ADD;
                FN_SUB:  oprn = OPRN_SUB;
                FN_MUL:  oprn = OPRN_MUL;
                FN_SRL:  begin oprn = OPRN_SRL; op2_sel = OP2_SHAMT; end
                FN_SLL:  begin oprn = OPRN_SLL; op2_sel = OP2_SHAMT; end
                FN_AND:  oprn = OPRN_AND;
                FN_OR:   oprn = OPRN_OR;
                FN_NOR:  oprn = OPRN_NOR;
                FN_SLT:  oprn = OPRN_SLT;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (instr[31:26])
                OPC_ADDI: begin oprn = OPRN_ADD; op2_sel = OP2_SEXT; end
                OPC_MULI: begin oprn = OPRN_MUL; op2_sel = OP2_SEXT; end
                OPC_SLTI: begin oprn = OPRN_SLT; op2_sel = OP2_SEXT; end
                OPC_ANDI: begin oprn = OPRN_AND; op2_sel = OP2_ZEXT; end
                OPC_ORI:  begin oprn = OPRN_OR;  op2_sel = OP2_ZEXT; end
                default:  illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction, drives the external ALU for SETTLE_CYCLES,
// captures its result and holds it until the consumer takes it.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [OPRN_W-1:0] alu_oprn,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              result_zero,
    output logic [REG_W-1:0]  dest,
    output logic              illegal
);
    logic [OPRN_W-1:0] dec_oprn;
    op2_sel_t          dec_sel;
    logic [REG_W-1:0]  dec_dest;
    logic              dec_ill;
    logic [DATA_W-1:0] op2_val;
    state_t            state;
    logic [3:0]        cnt;

    alu_instr_decode u_dec (
        .instr   (instr),
        .oprn    (dec_oprn),
        .op2_sel (dec_sel),
        .dest    (dec_dest),
        .illegal (dec_ill)
    );

    assign op2_val = dec_sel == OP2_SHAMT ? {27'b0, instr[10:6]} :
                     dec_sel == OP2_SEXT  ? {{16{instr[15]}}, instr[15:0]} :
                     dec_sel == OP2_ZEXT  ? {16'b0, instr[15:0]} : rt_data;

    // in_ready is registered, so it comes up on the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_oprn    <= OPRN_NOP;
            out_valid   <= 1'b0;
            result      <= '0;
            result_zero <= 1'b0;
            dest        <= '0;
            illegal     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready    <= 1'b0;
                        alu_op1     <= rs_data;
                        alu_op2     <= op2_val;
                        dest        <= dec_dest;
                        illegal     <= dec_ill;
                        result      <= '0;
                        result_zero <= 1'b0;
                        if (dec_ill) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            alu_oprn <= dec_oprn;
                            cnt      <= 4'(SETTLE_CYCLES);
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        result      <= alu_res;
                        result_zero <= alu_zero;
                        alu_oprn    <= OPRN_NOP;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives directed and random instructions through alu_issue_ctrl
// with a behavioural ALU attached, checking against an instruction-level model.
module tb_alu_issue_ctrl;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] alu_op1, alu_op2, alu_res, result;
    logic [5:0]  alu_oprn;
    logic        alu_zero, out_valid, result_zero, illegal;
    logic        out_ready = 1'b0;
    logic [4:0]  dest;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_oprn(alu_oprn),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_zero(result_zero), .dest(dest), .illegal(illegal)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        case (op)
            6'd1: return a + b;
            6'd2: return a - b;
            6'd3: return a * b;
            6'd4: return a >> b[4:0];
            6'd5: return a << b[4:0];
            6'd6: return a & b;
            6'd7: return a | b;
            6'd8: return ~(a | b);
            6'd9: return {31'b0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_res  = alu_f(alu_op1, alu_op2, alu_oprn);
        alu_zero = (alu_res == 32'd0);
    end

    function automatic void model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic ill, output logic [5:0] op, output logic [31:0] o2,
                                  output logic [4:0] d, output logic [31:0] res);
        logic [5:0]  opc;
        logic [31:0] sx, zx, sh;
        opc = ins[31:26];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'b0, ins[15:0]};
        sh  = {27'b0, ins[10:6]};
        ill = 1'b0;
        op  = 6'd0;
        o2  = rt;
        d   = (opc == 6'd0) ? ins[15:11] : ins[20:16];
        if (opc == 6'd0) begin
            case (ins[5:0])
                6'h20: op = 6'd1;
                6'h22: op = 6'd2;
                6'h2C: op = 6'd3;
                6'h02: begin op = 6'd4; o2 = sh; end
                6'h01: begin op = 6'd5; o2 = sh; end
                6'h24: op = 6'd6;
                6'h25: op = 6'd7;
                6'h27: op = 6'd8;
                6'h2A: op = 6'd9;
                default: ill = 1'b1;
            endcase
        end else begin
            case (opc)
                6'h08: begin op = 6'd1; o2 = sx; end
                6'h1D: begin op = 6'd3; o2 = sx; end
                6'h0A: begin op = 6'd9; o2 = sx; end
                6'h0C: begin op = 6'd6; o2 = zx; end
                6'h0D: begin op = 6'd7; o2 = zx; end
                default: ill = 1'b1;
            endcase
        end
        res = ill ? 32'd0 : alu_f(rs, o2, op);
    endfunction

    task automatic txn(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input int hold);
        logic ill;
        logic [5:0] op;
        logic [31:0] o2, res;
        logic [4:0] d;
        logic ez;
        int e;
        model(ins, rs, rt, ill, op, o2, d, res);
        ez = !ill && (res == 32'd0);
        e = 0;
        while (!in_ready && e < 20) begin @(negedge clk); e++; end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_wait in_ready=%b required 1", in_ready); end
        instr = ins; rs_data = rs; rt_data = rt; in_valid = 1'b1;
        @(negedge clk);
        e = 0;
        while (!out_valid && e < 40) begin
            in_valid = 1'($urandom); instr = $urandom; rs_data = $urandom; rt_data = $urandom;
            out_ready = 1'($urandom);
            checks++;
            if (in_ready !== 1'b0 || alu_oprn !== op || alu_op1 !== rs || alu_op2 !== o2) begin
                errors++;
                $display("FAIL issue instr=%h in_ready=%b oprn=%h op1=%h op2=%h required 0 %h %h %h",
                         ins, in_ready, alu_oprn, alu_op1, alu_op2, op, rs, o2);
            end
            @(negedge clk);
            e++;
        end
        checks++;
        if (e != (ill ? 0 : S)) begin errors++; $display("FAIL latency instr=%h got %0d required %0d", ins, e, ill ? 0 : S); end
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== res || result_zero !== ez || illegal !== ill ||
                alu_oprn !== 6'd0 || in_ready !== 1'b0 || (!ill && dest !== d)) begin
                errors++;
                $display("FAIL done instr=%h valid=%b res=%h z=%b ill=%b oprn=%h rdy=%b dest=%0d required 1 %h %b %b 0 0 %0d",
                         ins, out_valid, result, result_zero, illegal, alu_oprn, in_ready, dest, res, ez, ill, d);
            end
            if (i == hold) begin out_ready = 1'b1; in_valid = 1'b0; end
            else begin out_ready = 1'b0; in_valid = 1'($urandom); instr = $urandom; end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || alu_oprn !== 6'd0 || result !== 32'd0 ||
            illegal !== 1'b0 || dest !== 5'd0 || alu_op1 !== 32'd0 || alu_op2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state rdy=%b valid=%b oprn=%h res=%h ill=%b dest=%0d required all 0",
                     in_ready, out_valid, alu_oprn, result, illegal, dest);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_directed();
        txn(32'h00221820, 32'd5, 32'd7, 0);
        txn(32'h00221822, 32'h1234, 32'h1234, 1);
        txn(32'h00021901, 32'd1, 32'd99, 0);
        txn(32'h2022FFFF, 32'd1, 32'd0, 0);
        txn(32'hFC000000, 32'd3, 32'd4, 0);
        txn(32'h00221820, 32'd10, 32'd20, 5);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        logic [5:0] fn_tab [9];
        logic [5:0] op_tab [5];
        fn_tab = '{6'h20, 6'h22, 6'h2C, 6'h02, 6'h01, 6'h24, 6'h25, 6'h27, 6'h2A};
        op_tab = '{6'h08, 6'h1D, 6'h0C, 6'h0D, 6'h0A};
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 9) w = {6'h00, w[25:6], fn_tab[k]};
        else if (k < 14) w = {op_tab[k-9], w[25:0]};
        else if (k == 14) w = {6'h3F, w[25:0]};
        else w = {6'h00, w[25:6], 6'h3F};
        return w;
    endfunction

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 60; n++) begin
            a = $urandom; b = $urandom;
            if (n % 4 == 0) b = a;
            txn(rand_instr(), a, b, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_issue();
        int e;
        e = 0;
        while (!in_ready && e < 20) begin @(negedge clk); e++; end
        instr = 32'h00221820; rs_data = 32'd5; rt_data = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_oprn !== 6'd1) begin errors++; $display("FAIL issue2_oprn got %h required 01", alu_oprn); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_oprn !== 6'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset oprn=%h out_valid=%b required 0 0", alu_oprn, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset in_ready=%b required 1", in_ready); end
        for (int i = 0; i < S + 2; i++) begin
            checks++;
            if (out_valid !== 1'b0 || alu_oprn !== 6'd0) begin
                errors++;
                $display("FAIL discarded out_valid=%b oprn=%h required 0 0", out_valid, alu_oprn);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_in_issue();
        txn(32'h0022182A, 32'hFFFFFFFF, 32'd1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
